// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, FSM states and NZCV bit positions.
package alu_pkg;

   localparam logic [4:0] OP_ADDR = 5'b01000;
   localparam logic [4:0] OP_ADDI = 5'b01001;
   localparam logic [4:0] OP_SUBR = 5'b01010;
   localparam logic [4:0] OP_SUBI = 5'b01011;
   localparam logic [4:0] OP_MASR = 5'b01100;
   localparam logic [4:0] OP_MASI = 5'b01101;
   localparam logic [4:0] OP_LSL  = 5'b11000;
   localparam logic [4:0] OP_LSR  = 5'b11010;
   localparam logic [4:0] OP_ASR  = 5'b11011;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Radix-2 shift-add multiplier, one multiplier bit per step, LSB first; keeps the low WIDTH bits.
module mul_iter #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic             last,
   output logic [WIDTH-1:0] prod
);

   logic [WIDTH-1:0] mcand_sh;
   logic [WIDTH-1:0] mplier_sh;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;

   // prod is the accumulator after the current step, so on the last step it is the full product
   assign prod = acc + (mplier_sh[0] ? mcand_sh : '0);
   assign last = (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(WIDTH);
      end else if (step && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         mcand_sh  <= mcand;
         mplier_sh <= mplier;
         acc       <= '0;
      end else if (step) begin
         acc       <= prod;
         mcand_sh  <= mcand_sh << 1;
         mplier_sh <= mplier_sh >> 1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle datapath ALU: single-cycle ADD/SUB/shifts, iterative MAS, registered NZCV and a start/done handshake.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] rd_data,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rm_data,
   input  logic [WIDTH-1:0] imm,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             illegal
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   logic [3:0]       nzcv;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] operand2;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c;
   logic             sc_v;
   logic             sc_ill;
   logic             is_mas;
   logic             mul_load;
   logic             mul_last;
   logic [WIDTH-1:0] mul_prod;

   function automatic logic [3:0] pack_nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = r[WIDTH-1];
      f[FLAG_Z] = (r == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   assign is_mas   = (op == OP_MASR) || (op == OP_MASI);
   assign mul_load = (state == ST_IDLE) && start && is_mas;

   always_comb begin
      operand2 = op[0] ? imm : rm_data;
      sum_ext  = {1'b0, rs_data} + {1'b0, operand2};
      diff_ext = {1'b0, rs_data} - {1'b0, operand2};
      sc_res   = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      sc_ill   = 1'b0;
      case (op)
         OP_ADDR, OP_ADDI: begin
            sc_res = sum_ext[WIDTH-1:0];
            sc_c   = sum_ext[WIDTH];
            sc_v   = (rs_data[WIDTH-1] == operand2[WIDTH-1]) && (sum_ext[WIDTH-1] != rs_data[WIDTH-1]);
         end
         OP_SUBR, OP_SUBI: begin
            // carry means "no borrow", i.e. Rs >= operand unsigned
            sc_res = diff_ext[WIDTH-1:0];
            sc_c   = ~diff_ext[WIDTH];
            sc_v   = (rs_data[WIDTH-1] != operand2[WIDTH-1]) && (diff_ext[WIDTH-1] != rs_data[WIDTH-1]);
         end
         OP_MASR, OP_MASI: begin
            sc_ill = 1'b0;
         end
         OP_LSL: begin
            sc_res = {rs_data[WIDTH-2:0], 1'b0};
            sc_c   = rs_data[WIDTH-1];
         end
         OP_LSR: begin
            sc_res = {1'b0, rs_data[WIDTH-1:1]};
            sc_c   = rs_data[0];
         end
         OP_ASR: begin
            sc_res = {rs_data[WIDTH-1], rs_data[WIDTH-1:1]};
            sc_c   = rs_data[0];
         end
         default: sc_ill = 1'b1;
      endcase
   end

   mul_iter #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) u_mul (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (mul_load),
      .step   (state == ST_MUL),
      .mcand  (rd_data),
      .mplier (rs_data),
      .last   (mul_last),
      .prod   (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (mul_load) begin
         addend <= operand2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         nzcv    <= '0;
         illegal <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && is_mas) begin
                  state <= ST_MUL;
                  busy  <= 1'b1;
               end else if (start) begin
                  done    <= 1'b1;
                  result  <= sc_res;
                  nzcv    <= pack_nzcv(sc_res, sc_c, sc_v);
                  illegal <= sc_ill;
               end
            end
            ST_MUL: begin
               if (mul_last) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  result  <= mul_prod + addend;
                  nzcv    <= pack_nzcv(mul_prod + addend, 1'b0, 1'b0);
                  illegal <= 1'b0;
               end
            end
         endcase
      end
   end

   assign flag_n = nzcv[FLAG_N];
   assign flag_z = nzcv[FLAG_Z];
   assign flag_c = nzcv[FLAG_C];
   assign flag_v = nzcv[FLAG_V];

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver pushes model expectations, a monitor pops and checks on each done.
module tb_alu_mc;

   localparam int W = 16;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  nzcv;
      logic        ill;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  op = '0;
   logic [15:0] rd_data = '0, rs_data = '0, rm_data = '0, imm = '0;
   logic        busy, done, flag_z, flag_n, flag_c, flag_v, illegal;
   logic [15:0] result;

   logic        start8 = 1'b0;
   logic [4:0]  op8 = '0;
   logic [7:0]  rd8 = '0, rs8 = '0, rm8 = '0, imm8 = '0;
   logic        busy8, done8, z8, n8, c8, v8, ill8;
   logic [7:0]  result8;

   int   cyc = 0;
   int   chk = 0;
   int   pass = 0;
   int   busy_start = 0;
   int   busy_end = -1;
   bit   mon_en = 1'b0;
   exp_t sbq[$];

   alu_mc #(.WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .rd_data(rd_data), .rs_data(rs_data), .rm_data(rm_data), .imm(imm),
      .busy(busy), .done(done), .result(result),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal)
   );

   alu_mc #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .op(op8),
      .rd_data(rd8), .rs_data(rs8), .rm_data(rm8), .imm(imm8),
      .busy(busy8), .done(done8), .result(result8),
      .flag_z(z8), .flag_n(n8), .flag_c(c8), .flag_v(v8), .illegal(ill8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      chk++;
      if (act == req) pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic bit op_is_mas(input logic [4:0] o);
      return (o == 5'b01100) || (o == 5'b01101);
   endfunction

   // Reference behaviour from plain integer arithmetic on the architectural definitions
   function automatic exp_t model(input logic [4:0] o, input logic [15:0] d, s, m, i);
      exp_t        e;
      int unsigned a, b, r;
      int          sa, sb;
      longint      p;
      bit          c, v, ill;
      a = s;
      b = o[0] ? i : m;
      sa = $signed(s);
      sb = o[0] ? $signed(i) : $signed(m);
      c = 0; v = 0; ill = 0; r = 0;
      case (o)
         5'b01000, 5'b01001: begin
            r = a + b; c = (r >= 65536);
            v = (sa + sb > 32767) || (sa + sb < -32768);
         end
         5'b01010, 5'b01011: begin
            r = a + 65536 - b; c = (a >= b);
            v = (sa - sb > 32767) || (sa - sb < -32768);
         end
         5'b01100, 5'b01101: begin
            p = longint'(d) * longint'(s) + longint'(b);
            r = int'(p % 65536);
         end
         5'b11000: begin r = a * 2; c = (a >= 32768); end
         5'b11010: begin r = a / 2; c = (a % 2 == 1); end
         5'b11011: begin r = a / 2 + ((a >= 32768) ? 32768 : 0); c = (a % 2 == 1); end
         default: begin r = 0; ill = 1; end
      endcase
      r = r % 65536;
      e.res  = r[15:0];
      e.nzcv = {(r >= 32768), (r == 0), c, v};
      e.ill  = ill;
      e.cyc  = 0;
      return e;
   endfunction

   task automatic issue(input logic [4:0] o, input logic [15:0] d, s, m, i);
      exp_t e;
      op = o; rd_data = d; rs_data = s; rm_data = m; imm = i; start = 1'b1;
      if (!(cyc >= busy_start && cyc <= busy_end)) begin
         e = model(o, d, s, m, i);
         if (op_is_mas(o)) begin
            e.cyc = cyc + W + 1;
            busy_start = cyc + 1;
            busy_end = cyc + W;
         end else begin
            e.cyc = cyc + 1;
         end
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      op = 5'($urandom); rd_data = 16'($urandom); rs_data = 16'($urandom);
      rm_data = 16'($urandom); imm = 16'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      int n = 0;
      while ((sbq.size() != 0 || busy) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_pending", sbq.size(), 0);
   endtask

   function automatic logic [15:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'h0001;
         2: return 16'h7FFF;
         3: return 16'h8000;
         4: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         check("busy", busy, (cyc >= busy_start && cyc <= busy_end));
         if (done) begin
            if (sbq.size() == 0) begin
               check("done_unexpected", done, 0);
            end else begin
               e = sbq.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("result", result, e.res);
               check("nzcv", {flag_n, flag_z, flag_c, flag_v}, e.nzcv);
               check("illegal", illegal, e.ill);
            end
         end
      end
   end

   initial begin
      logic [4:0] legal [9];
      logic [4:0] o;
      int k, dcyc;
      bit got;
      legal = '{5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
                5'b01101, 5'b11000, 5'b11010, 5'b11011};

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
      check("rst_illegal", illegal, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      idle(2);

      issue(5'b01000, 16'h0, 16'h7FFF, 16'h0001, 16'h0);
      issue(5'b01011, 16'h0, 16'h0005, 16'h0, 16'h0005);
      issue(5'b01010, 16'h0, 16'h0003, 16'h0004, 16'h0);
      issue(5'b11011, 16'h0, 16'h8002, 16'h0, 16'h0);
      issue(5'b11010, 16'h0, 16'h0001, 16'h0, 16'h0);
      issue(5'b11000, 16'h0, 16'h8000, 16'h0, 16'h0);
      issue(5'b00000, 16'h0, 16'h1234, 16'h0, 16'h0);
      drain();

      issue(5'b01100, 16'd3, 16'd5, 16'd7, 16'h0);
      idle(3);
      issue(5'b01000, 16'h0, 16'h1111, 16'h2222, 16'h0);
      drain();

      issue(5'b01101, 16'd9, 16'd11, 16'h0, 16'd4);
      idle(W - 1);
      issue(5'b01001, 16'h0, 16'h0010, 16'h0, 16'h0020);
      drain();

      issue(5'b01000, 16'h0, 16'h0001, 16'h0001, 16'h0);
      issue(5'b01100, 16'd100, 16'd200, 16'd5, 16'h0);
      idle(7);
      reset_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
      sbq.delete();
      busy_start = 0;
      busy_end = -1;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      issue(5'b01000, 16'h0, 16'h0100, 16'h0023, 16'h0);
      drain();

      for (int n = 0; n < 300; n++) begin
         o = legal[$urandom_range(0, 8)];
         if ($urandom_range(0, 9) == 0) o = 5'($urandom);
         issue(o, pick_val(), pick_val(), pick_val(), pick_val());
         idle($urandom_range(0, 2));
      end
      drain();

      k = cyc;
      start8 = 1'b1; op8 = 5'b01101; rd8 = 8'd15; rs8 = 8'd17; rm8 = 8'd0; imm8 = 8'd1;
      @(posedge clk); #1;
      start8 = 1'b0; rd8 = 8'hAA; rs8 = 8'h55; imm8 = 8'h33;
      got = 0; dcyc = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (done8) begin got = 1; dcyc = cyc; end
      end
      check("w8_mas_done_seen", got, 1);
      check("w8_mas_done_cycle", dcyc, k + 9);
      check("w8_mas_result", result8, 8'h00);
      check("w8_mas_z", z8, 1);
      @(posedge clk); #1;
      k = cyc;
      start8 = 1'b1; op8 = 5'b00000; rs8 = 8'h5A;
      @(posedge clk); #1;
      start8 = 1'b0;
      got = 0; dcyc = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (done8) begin got = 1; dcyc = cyc; end
      end
      check("w8_ill_done_cycle", dcyc, k + 1);
      check("w8_ill_flag", ill8, 1);
      check("w8_ill_result", result8, 8'h00);

      idle(2);
      check("final_queue_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
